mem_access: RTL and testbench

- MEM-stage access unit. It is the consumer side of the execute stage's memory-request outputs: address/result, store data, read/write strobes, byte flag, and register-write pass-through.
- Turns each load/store into a request/acknowledge transaction on the data-SRAM bus, with byte-lane steering and LB sign extension.
- Stalls the pipeline until the bus completes, then presents write-back data to the WB stage.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access.sv | 149 ++++++++++++++
 tb/tb_mem_access.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage access unit: load/store to req/ack SRAM bus with lane steering and LB sign extension.
// Latency: ALU ops 1 cycle; memory ops 1 cycle after ack/timeout; mem_stall holds upstream until then.
module mem_access #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_result,
  input  logic [31:0] in_mem_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_load_byte,
  input  logic        in_reg_write,
  input  logic [4:0]  in_write_reg,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane;
  logic        is_byte;
  logic        ld_reg_write;
  logic [4:0]  ld_reg;

  logic        mem_op;
  logic        misaligned;
  logic        timeout;
  logic [7:0]  rbyte;
  logic [31:0] load_data;

  assign mem_op     = in_valid & (in_mem_read | in_mem_write);
  assign misaligned = mem_op & ~in_load_byte & (in_result[1:0] != 2'b00);
  assign timeout    = (state == WAIT) & ~bus_ack & (cnt == TIMEOUT_CYCLES - 8'd1);
  // Upstream may advance in the ack/timeout cycle; in_* is only re-sampled once back in IDLE.
  assign mem_stall  = (state == IDLE) ? (mem_op & ~misaligned) : ~(bus_ack | timeout);

  always_comb begin
    rbyte = bus_rdata[7:0];
    case (lane)
      2'd1:    rbyte = bus_rdata[15:8];
      2'd2:    rbyte = bus_rdata[23:16];
      2'd3:    rbyte = bus_rdata[31:24];
      default: rbyte = bus_rdata[7:0];
    endcase
    load_data = is_byte ? {{24{rbyte[7]}}, rbyte} : bus_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      lane         <= 2'd0;
      is_byte      <= 1'b0;
      ld_reg_write <= 1'b0;
      ld_reg       <= 5'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= 32'd0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (mem_op && !misaligned) begin
            state        <= WAIT;
            bus_req      <= 1'b1;
            bus_we       <= in_mem_write;
            bus_addr     <= {in_result[31:2], 2'b00};
            bus_be       <= (in_mem_write && in_load_byte) ? (4'b0001 << in_result[1:0]) : 4'b1111;
            bus_wdata    <= in_load_byte ? {4{in_mem_data[7:0]}} : in_mem_data;
            lane         <= in_result[1:0];
            is_byte      <= in_load_byte;
            ld_reg_write <= in_reg_write;
            ld_reg       <= in_write_reg;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else if (misaligned) begin
            addr_err     <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_reg       <= in_write_reg;
            wb_data      <= in_result;
          end else if (in_valid) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_reg       <= in_write_reg;
            wb_data      <= in_result;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            cnt      <= 8'd0;
            wb_valid <= 1'b1;
            wb_reg   <= ld_reg;
            if (bus_we) begin
              wb_reg_write <= 1'b0;
              wb_data      <= 32'd0;
            end else begin
              wb_reg_write <= ld_reg_write;
              wb_data      <= load_data;
            end
          end else if (timeout) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            cnt          <= 8'd0;
            bus_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_reg       <= ld_reg;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table driven back-to-back, bus and write-back scoreboards, corner sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = '0;
  logic [31:0] in_mem_data = '0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        in_load_byte = 1'b0;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_write_reg = '0;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        addr_err;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result), .in_mem_data(in_mem_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_load_byte(in_load_byte),
    .in_reg_write(in_reg_write), .in_write_reg(in_write_reg),
    .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
  } bus_exp_t;
  typedef struct {
    logic rw; logic [4:0] rg; logic [31:0] data; logic chk_data; logic aerr; logic berr;
  } wb_exp_t;
  typedef struct {
    logic rd; logic wr; logic lb; logic rw; logic [4:0] rg;
    logic [31:0] addr; logic [31:0] wdata;
    int lat; logic [31:0] rdata; int stall;
    logic exp_bus; logic [3:0] exp_be; logic [31:0] exp_wdata;
    logic e_rw; logic [31:0] e_data; logic e_chk; logic e_aerr; logic e_berr;
  } vec_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  bus_exp_t be_cur;
  wb_exp_t  we_cur;

  // Bus responder: acks in the cur_lat-th request cycle (0 = never); cur_hold < 0 skips the length check.
  int          req_cnt = 0;
  int          cur_lat = 0;
  int          cur_hold = -1;
  int          n_txn = 0;
  int          exp_txn = 0;
  logic [31:0] cur_rdata = '0;
  logic        idle_ack = 1'b0;

  always @(negedge clk) begin
    if (bus_req) begin
      req_cnt++;
      if (req_cnt == 1) begin
        n_txn++;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_req", 32'd1, 32'd0);
        end else begin
          be_cur = bus_q.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, be_cur.we});
          chk("bus_addr", bus_addr, be_cur.addr);
          chk("bus_be", {28'd0, bus_be}, {28'd0, be_cur.be});
          if (be_cur.we) chk("bus_wdata", bus_wdata, be_cur.wdata);
        end
      end
      bus_ack   = (cur_lat != 0) && (req_cnt == cur_lat);
      bus_rdata = bus_ack ? cur_rdata : 32'h5A5A_5A5A;
    end else begin
      if (req_cnt > 0 && cur_hold >= 0) chk("bus_req_cycles", req_cnt, cur_hold);
      req_cnt   = 0;
      bus_ack   = idle_ack;
      bus_rdata = 32'h5A5A_5A5A;
    end
  end

  // Write-back monitor: every wb_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        we_cur = wb_q.pop_front();
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, we_cur.rw});
        if (we_cur.rw) chk("wb_reg", {27'd0, wb_reg}, {27'd0, we_cur.rg});
        if (we_cur.chk_data) chk("wb_data", wb_data, we_cur.data);
        chk("addr_err", {31'd0, addr_err}, {31'd0, we_cur.aerr});
        chk("bus_err", {31'd0, bus_err}, {31'd0, we_cur.berr});
      end
    end else if (rst) begin
      chk("stray_err_pulse", {30'd0, addr_err, bus_err}, 32'd0);
    end
  end

  task automatic issue(input vec_t v);
    int cycles;
    #1;
    cur_lat   = v.lat;
    cur_rdata = v.rdata;
    cur_hold  = v.exp_bus ? ((v.lat == 0) ? 4 : v.lat) : -1;
    in_valid = 1'b1; in_mem_read = v.rd; in_mem_write = v.wr; in_load_byte = v.lb;
    in_reg_write = v.rw; in_write_reg = v.rg; in_result = v.addr; in_mem_data = v.wdata;
    if (v.exp_bus) begin
      bus_q.push_back('{v.wr, {v.addr[31:2], 2'b00}, v.exp_be, v.exp_wdata});
      exp_txn++;
    end
    wb_q.push_back('{v.e_rw, v.rg, v.e_data, v.e_chk, v.e_aerr, v.e_berr});
    #1;
    cycles = 0;
    while (mem_stall === 1'b1 && cycles < 40) begin
      @(negedge clk); #2;
      cycles++;
    end
    chk("stall_cycles", cycles, v.stall);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[16];

  initial begin
    //          rd wr lb rw reg    addr           wdata         lat rdata          stall bus be       bus_wdata      e_rw e_data        chk aerr berr
    vecs[0]  = '{0, 0, 0, 1, 5'd8,  32'h1234_5678, 32'h0,         0, 32'h0,          0,    0, 4'h0,    32'h0,         1, 32'h1234_5678, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 5'd3,  32'h0000_0010, 32'h0,         2, 32'hDEAD_BEEF,  2,    1, 4'hF,    32'h0,         1, 32'hDEAD_BEEF, 1, 0, 0};
    vecs[2]  = '{1, 0, 1, 1, 5'd4,  32'h0000_0013, 32'h0,         1, 32'h80FF_0011,  1,    1, 4'hF,    32'h0,         1, 32'hFFFF_FF80, 1, 0, 0};
    vecs[3]  = '{1, 0, 1, 1, 5'd4,  32'h0000_0012, 32'h0,         3, 32'h80FF_0011,  3,    1, 4'hF,    32'h0,         1, 32'hFFFF_FFFF, 1, 0, 0};
    vecs[4]  = '{1, 0, 1, 1, 5'd4,  32'h0000_0010, 32'h0,         1, 32'h80FF_0011,  1,    1, 4'hF,    32'h0,         1, 32'h0000_0011, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 1, 5'd9,  32'h0000_0006, 32'h0000_00AB, 2, 32'h0,          2,    1, 4'b0100, 32'hABAB_ABAB, 0, 32'h0,         0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 5'd0,  32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0,          1,    1, 4'hF,    32'hCAFE_F00D, 0, 32'h0,         0, 0, 0};
    vecs[7]  = '{1, 0, 0, 1, 5'd5,  32'h0000_0002, 32'h0,         0, 32'h0,          0,    0, 4'h0,    32'h0,         0, 32'h0,         0, 1, 0};
    vecs[8]  = '{1, 1, 0, 1, 5'd6,  32'h0000_0008, 32'h1122_3344, 1, 32'h9999_9999,  1,    1, 4'hF,    32'h1122_3344, 0, 32'h0,         0, 0, 0};
    vecs[9]  = '{1, 0, 1, 1, 5'd7,  32'h0000_0011, 32'h0,         2, 32'h0000_7F00,  2,    1, 4'hF,    32'h0,         1, 32'h0000_007F, 1, 0, 0};
    vecs[10] = '{1, 0, 0, 1, 5'd10, 32'h0000_0040, 32'h0,         0, 32'h0,          4,    1, 4'hF,    32'h0,         0, 32'h0,         0, 0, 1};
    vecs[11] = '{1, 0, 0, 1, 5'd11, 32'h0000_0044, 32'h0,         1, 32'h0000_0001,  1,    1, 4'hF,    32'h0,         1, 32'h0000_0001, 1, 0, 0};
    vecs[12] = '{1, 0, 0, 1, 5'd12, 32'h0000_0048, 32'h0,         2, 32'h0BAD_CAFE,  2,    1, 4'hF,    32'h0,         1, 32'h0BAD_CAFE, 1, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 5'd0,  32'h0000_0001, 32'h0000_0055, 0, 32'h0,          0,    0, 4'h0,    32'h0,         0, 32'h0,         0, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 5'd2,  32'hFFFF_0000, 32'h0,         0, 32'h0,          0,    0, 4'h0,    32'h0,         0, 32'hFFFF_0000, 1, 0, 0};
    vecs[15] = '{0, 1, 1, 0, 5'd0,  32'h0000_0003, 32'h1234_5677, 1, 32'h0,          1,    1, 4'b1000, 32'h7777_7777, 0, 32'h0,         0, 0, 0};

    #1 rst = 1'b0;
    #2;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) issue(vecs[i]);

    // Ack while idle must be ignored.
    #1 idle_ack = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("idle_ack_bus_req", {31'd0, bus_req}, 32'd0);
    chk("idle_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("idle_ack_stall", {31'd0, mem_stall}, 32'd0);
    idle_ack = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a WAIT: request drops at once, nothing completes.
    #1;
    cur_lat = 0; cur_hold = -1; cur_rdata = '0;
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_load_byte = 1'b0;
    in_reg_write = 1'b1; in_write_reg = 5'd13; in_result = 32'h0000_0050;
    bus_q.push_back('{1'b0, 32'h0000_0050, 4'hF, 32'h0});
    exp_txn++;
    repeat (2) @(negedge clk);
    #2;
    chk("midwait_bus_req", {31'd0, bus_req}, 32'd1);
    chk("midwait_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0;
    #1;
    chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("async_rst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    issue(vecs[1]);
    issue(vecs[0]);
    repeat (3) @(negedge clk);
    #2;
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    chk("txn_count", n_txn, exp_txn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
